intellight_q_updater: RTL
=========================

INTELLIGHT_Q_UPDATER -- requirements
Module: intellight_q_updater

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- STATE_W, 8, state index width (2^STATE_W traffic states).
- Q_W, 16, signed Q-value width.
- ALPHA_SH, 2, learning rate alpha = 2^-ALPHA_SH.
- GAMMA_SH, 3, discount gamma = 1 - 2^-GAMMA_SH.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- ACLK, in, 1, sole clock, rising edge.
- ARESETN, in, 1, synchronous active-low reset.
- start, in, 1, request one update; sampled in IDLE only.
- state_cur, in, STATE_W, current state s.
- action, in, 2, action a taken in s.
- state_nxt, in, STATE_W, resulting state s'.
- reward, in, Q_W, signed reward R.
- busy, out, 1, update in progress.
- done, out, 1, one-cycle completion pulse.
- q_new, out, Q_W, last written Q(s,a); held until next done.
- best_act, out, 2, greedy argmax action in s'; held until next done.
- mem_addr, out, STATE_W+2, Q-table address {state, action}.
- mem_rd_en, out, 1, Q-table read strobe; data valid one cycle later.
- mem_rdata, in, Q_W, Q-table read data.
- mem_wr_en, out, 1, Q-table write strobe.
- mem_wdata, out, Q_W, Q-table write data.

Function
REQ-003 FSM states SHALL be IDLE, READ, DRAIN, CALC, WRITE.
REQ-004 IDLE with start=1 SHALL latch state_cur, action, state_nxt, reward and go to READ; start in any other state SHALL be ignored.
REQ-005 READ SHALL last 5 cycles with mem_rd_en=1 and mem_addr = {s,a}, then {s',0}, {s',1}, {s',2}, {s',3}.
REQ-006 Each mem_rdata SHALL be captured one cycle after its read; DRAIN SHALL capture the fifth word, then go to CALC.
REQ-007 max over Q(s',0..3) SHALL be a signed compare; best_act SHALL be the lowest index on ties.
REQ-008 CALC SHALL compute, in Q_W+3-bit signed arithmetic:
- g = M - (M >>> GAMMA_SH), where M is the max from REQ-007.
- td = R + g - Q(s,a).
- Qn = Q(s,a) + (td >>> ALPHA_SH); arithmetic shifts floor toward -infinity.
REQ-009 Qn SHALL saturate to [-2^(Q_W-1), 2^(Q_W-1)-1].
REQ-010 WRITE SHALL last 1 cycle: mem_wr_en=1, mem_addr={s,a}, mem_wdata=Qn, done=1; q_new and best_act SHALL update at the same edge; next state IDLE.
REQ-011 Latency: start sampled at edge 0; busy high cycles 1-8; WRITE/done in cycle 8; a new start SHALL be accepted in cycle 9.
REQ-012 If s == s', all reads SHALL complete before the write, so the pre-update Q values are used.
REQ-013 mem_rd_en and mem_wr_en SHALL never be high in the same cycle; mem_addr SHALL be 0 whenever neither strobe is high.

Reset
REQ-014 ARESETN=0 at a rising edge SHALL force IDLE, busy=0, done=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, q_new=0, best_act=0.
REQ-015 Reset in any state, including mid-READ or in CALC, SHALL abort with no write issued; start held during reset SHALL be ignored.

Structure
REQ-016 Package intellight_pkg SHALL hold the FSM state enum, the default values of STATE_W/Q_W/ALPHA_SH/GAMMA_SH, and a saturate function.
REQ-017 The combinational TD datapath (REQ-008/009) SHALL be sub-module intellight_q_arith; FSM, capture registers and max tracking SHALL stay in intellight_q_updater.

Verification
REQ-018 Benches SHALL use a 1-cycle-latency RAM model and the default parameters, and SHALL cover:
- Table all 0, s=5, a=2, s'=9, R=800 -> one write at addr {5,2} with data 200 in cycle 8; done single pulse; best_act=0.
- Q(s,a)=100, Q(s',*)={40,160,160,-5}, R=0 -> wdata 110, best_act=1.
- Q(s,a)=32000, all Q(s',*)=32767, R=32767 -> wdata 32767 (saturated).
- Table 0, R=-10 -> wdata -3 (floor).
- ARESETN low in 3rd READ cycle -> no mem_wr_en, busy=0 next cycle; start pulsed while busy ignored; back-to-back start in cycle 9 accepted.
- s=s'=7, a=1, Q(7,*)={0,400,0,0}, R=0 -> Qn = 400 + ((350-400)>>>2) = 387, best_act=1.

Source files
------------

// File: rtl/intellight_pkg.sv
// Shared types and defaults for the IntelLight Q-table updater.
// Holds the FSM state encoding, parameter defaults and signed saturation helper.
package intellight_pkg;

  localparam int STATE_W_DEF  = 8;
  localparam int Q_W_DEF      = 16;
  localparam int ALPHA_SH_DEF = 2;
  localparam int GAMMA_SH_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    CALC,
    WRITE
  } state_t;

  // Clamp a sign-extended value into the range of a w-bit signed number.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/intellight_q_arith.sv
// Combinational TD update: Qn = sat(Q + ((R + gamma*M - Q) >>> ALPHA_SH)), zero latency.
// Pure datapath, no handshake; widened by 3 bits so intermediates never wrap.
module intellight_q_arith
  import intellight_pkg::*;
#(
  parameter int Q_W      = Q_W_DEF,
  parameter int ALPHA_SH = ALPHA_SH_DEF,
  parameter int GAMMA_SH = GAMMA_SH_DEF
) (
  input  logic signed [Q_W-1:0] i_q_sa,
  input  logic signed [Q_W-1:0] i_q_max,
  input  logic signed [Q_W-1:0] i_reward,
  output logic signed [Q_W-1:0] o_q_new
);

  localparam int W = Q_W + 3;

  logic signed [W-1:0] w_m;
  logic signed [W-1:0] w_q;
  logic signed [W-1:0] w_r;
  logic signed [W-1:0] w_g;
  logic signed [W-1:0] w_td;
  logic signed [W-1:0] w_qn;

  assign w_m  = W'(i_q_max);
  assign w_q  = W'(i_q_sa);
  assign w_r  = W'(i_reward);

  // gamma * M with gamma = 1 - 2^-GAMMA_SH, realised as a subtract of a shifted copy
  assign w_g  = w_m - (w_m >>> GAMMA_SH);
  assign w_td = w_r + w_g - w_q;
  assign w_qn = w_q + (w_td >>> ALPHA_SH);

  assign o_q_new = Q_W'(saturate(32'(w_qn), Q_W));

endmodule

// File: rtl/intellight_q_updater.sv
// One Q-learning update per start: 5 reads, drain, calc, 1 write; busy for 8 cycles.
// start is only sampled in IDLE; requests while busy are dropped, not queued.
module intellight_q_updater
  import intellight_pkg::*;
#(
  parameter int STATE_W  = STATE_W_DEF,
  parameter int Q_W      = Q_W_DEF,
  parameter int ALPHA_SH = ALPHA_SH_DEF,
  parameter int GAMMA_SH = GAMMA_SH_DEF
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 start,
  input  logic [STATE_W-1:0]   state_cur,
  input  logic [1:0]           action,
  input  logic [STATE_W-1:0]   state_nxt,
  input  logic [Q_W-1:0]       reward,
  output logic                 busy,
  output logic                 done,
  output logic [Q_W-1:0]       q_new,
  output logic [1:0]           best_act,
  output logic [STATE_W+1:0]   mem_addr,
  output logic                 mem_rd_en,
  input  logic [Q_W-1:0]       mem_rdata,
  output logic                 mem_wr_en,
  output logic [Q_W-1:0]       mem_wdata
);

  state_t                r_state;
  logic [STATE_W-1:0]    r_s;
  logic [1:0]            r_a;
  logic [STATE_W-1:0]    r_sn;
  logic signed [Q_W-1:0] r_r;
  logic [2:0]            r_cnt;
  logic signed [Q_W-1:0] r_q_sa;
  logic signed [Q_W-1:0] r_max;
  logic [1:0]            r_best;

  logic signed [Q_W-1:0] w_rdata;
  logic signed [Q_W-1:0] w_qn;
  logic                  w_cap_vld;
  logic [2:0]            w_cap_idx;

  assign w_rdata = mem_rdata;

  // Word k of the read burst arrives one cycle after it was issued:
  // 0 = Q(s,a), 1..4 = Q(s',0..3). The last one lands during DRAIN.
  always_comb begin
    w_cap_vld = 1'b0;
    w_cap_idx = 3'd0;
    if (r_state == READ && r_cnt != 3'd0) begin
      w_cap_vld = 1'b1;
      w_cap_idx = r_cnt - 3'd1;
    end else if (r_state == DRAIN) begin
      w_cap_vld = 1'b1;
      w_cap_idx = 3'd4;
    end
  end

  intellight_q_arith #(
    .Q_W      (Q_W),
    .ALPHA_SH (ALPHA_SH),
    .GAMMA_SH (GAMMA_SH)
  ) u_arith (
    .i_q_sa   (r_q_sa),
    .i_q_max  (r_max),
    .i_reward (r_r),
    .o_q_new  (w_qn)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state   <= IDLE;
      r_s       <= '0;
      r_a       <= '0;
      r_sn      <= '0;
      r_r       <= '0;
      r_cnt     <= '0;
      r_q_sa    <= '0;
      r_max     <= '0;
      r_best    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      q_new     <= '0;
      best_act  <= '0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_s       <= state_cur;
            r_a       <= action;
            r_sn      <= state_nxt;
            r_r       <= reward;
            r_cnt     <= 3'd0;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
            mem_addr  <= {state_cur, action};
            r_state   <= READ;
          end
        end
        READ: begin
          if (r_cnt == 3'd4) begin
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            r_state   <= DRAIN;
          end else begin
            // next issued word is r_cnt+1, i.e. Q(s', r_cnt)
            mem_addr  <= {r_sn, r_cnt[1:0]};
            r_cnt     <= r_cnt + 3'd1;
          end
        end
        DRAIN: begin
          r_state <= CALC;
        end
        CALC: begin
          mem_wr_en <= 1'b1;
          mem_addr  <= {r_s, r_a};
          mem_wdata <= w_qn;
          done      <= 1'b1;
          q_new     <= w_qn;
          best_act  <= r_best;
          r_state   <= WRITE;
        end
        WRITE: begin
          mem_wr_en <= 1'b0;
          mem_addr  <= '0;
          done      <= 1'b0;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_cap_vld) begin
        case (w_cap_idx)
          3'd0: r_q_sa <= w_rdata;
          3'd1: begin
            r_max  <= w_rdata;
            r_best <= 2'd0;
          end
          default: begin
            // strict compare keeps the lowest action index on ties
            if (w_rdata > r_max) begin
              r_max  <= w_rdata;
              r_best <= 2'(w_cap_idx - 3'd1);
            end
          end
        endcase
      end
    end
  end

endmodule
